// File: rtl/pc.sv
// Program counter for the Nibbler CPU core: holds, increments or loads a jump target each clock.
// Define PC_PHASE_EN to add the fetch/execute phase flag output.
module pc #(
    parameter int unsigned    AW       = 12,
    parameter logic [AW-1:0]  RST_ADDR = '0
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic [AW-1:0] newaddr,
    input  logic          loadPC,
    input  logic          incPC,
`ifdef PC_PHASE_EN
    output logic          phase,
`endif
    output logic [AW-1:0] addr
);

    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_next;

    // Load wins over increment; the add wraps naturally at AW bits.
    always_comb begin
        w_addr_next = r_addr;
        if (loadPC) begin
            w_addr_next = newaddr;
        end else if (incPC) begin
            w_addr_next = r_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_addr <= RST_ADDR;
        end else begin
            r_addr <= w_addr_next;
        end
    end

    assign addr = r_addr;

`ifdef PC_PHASE_EN
    logic r_phase;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign phase = r_phase;
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed scenarios followed by randomized load/inc/reset traffic.
// Phase checks are compiled in only when PC_PHASE_EN is defined.
module tb_pc;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          Rst;
    logic          loadPC;
    logic          incPC;
    logic [AW-1:0] newaddr;
    logic [AW-1:0] addr;
`ifdef PC_PHASE_EN
    logic          phase;
    int            exp_phase;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_addr;

    always #5 clk = ~clk;

    pc #(
        .AW       (AW),
        .RST_ADDR (12'h000)
    ) dut (
        .clk     (clk),
        .Rst     (Rst),
        .newaddr (newaddr),
        .loadPC  (loadPC),
        .incPC   (incPC),
`ifdef PC_PHASE_EN
        .phase   (phase),
`endif
        .addr    (addr)
    );

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("%s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk(tag, addr, AW'(exp_addr));
`ifdef PC_PHASE_EN
        chk({tag, "_phase"}, AW'(phase), AW'(exp_phase));
`endif
    endtask

    // Reference behaviour of one rising edge with Rst released.
    task automatic model_edge(input logic ld, input logic inc, input logic [AW-1:0] na);
        if (ld) begin
            exp_addr = na;
        end else if (inc) begin
            exp_addr = (exp_addr + 1) % (1 << AW);
        end
`ifdef PC_PHASE_EN
        exp_phase = 1 - exp_phase;
`endif
    endtask

    task automatic step(input logic ld, input logic inc, input logic [AW-1:0] na,
                        input string tag);
        @(negedge clk);
        loadPC  = ld;
        incPC   = inc;
        newaddr = na;
        @(posedge clk);
        #1;
        model_edge(ld, inc, na);
        chk_all(tag);
    endtask

    // Assert reset between edges, check immediate effect and that it holds across edges.
    task automatic mid_reset(input int hold_edges);
        @(posedge clk);
        #2;
        Rst = 1'b0;
        #1;
        exp_addr = 0;
`ifdef PC_PHASE_EN
        exp_phase = 0;
`endif
        chk_all("rst_async");
        loadPC = 1'bx;
        incPC  = 1'bx;
        for (int i = 0; i < hold_edges; i++) begin
            @(posedge clk);
            #1;
            chk_all("rst_hold");
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        Rst    = 1'b1;
        loadPC = 1'b0;
        incPC  = 1'b0;
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b0, '0);
        chk_all("rst_release");
    endtask

    initial begin
        Rst      = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        newaddr  = '0;
        exp_addr = 0;
`ifdef PC_PHASE_EN
        exp_phase = 0;
`endif
        #12;
        chk_all("reset_val");
        release_reset();

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 12'h000, "count");
        step(1'b0, 1'b1, 12'h000, "count");
        step(1'b0, 1'b1, 12'h000, "count");
        chk("at_7", addr, 12'h007);

        mid_reset(2);
        release_reset();

        step(1'b1, 1'b1, 12'h359, "load_prio");
        chk("load_prio_abs", addr, 12'h359);
        step(1'b0, 1'b1, 12'hABC, "inc_after_load");
        chk("inc_after_load_abs", addr, 12'h35A);

        step(1'b1, 1'b0, 12'h123, "load_123");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h555, "hold");
        chk("hold_abs", addr, 12'h123);

        step(1'b1, 1'b0, 12'hFFE, "load_FFE");
        step(1'b0, 1'b1, 12'h000, "wrap_FFF");
        step(1'b0, 1'b1, 12'h000, "wrap_000");
        chk("wrap_abs", addr, 12'h000);

        step(1'b1, 1'b0, 12'hFFF, "load_FFF");
        step(1'b0, 1'b1, 12'h000, "inc_from_FFF");

        for (int i = 0; i < 400; i++) begin
            logic          ld;
            logic          inc;
            logic [AW-1:0] na;
            ld  = ($urandom_range(0, 3) == 0);
            inc = 1'($urandom_range(0, 1));
            na  = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                mid_reset($urandom_range(0, 2));
                release_reset();
            end else begin
                step(ld, inc, na, "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
